reg_readback_tx: RTL and testbench

//  Read-response stage beside command_parser_uart: on a read request, reads one register_block entry and returns it over UART.

---
 rtl/reg_readback_tx.sv | 147 ++++++++++++++
 tb/tb_reg_readback_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_readback_tx.sv
// reg_readback_tx
//   Read-response stage: on a read request, strobes one register_block read,
//   captures the returned value, then streams a response frame to uart_tx one
//   byte at a time.
//   Frame: RESP_CODE, address, value bytes MSB first (VALUE_WORDS+2 bytes).
// Ports
//   clk, i_reset            clock, synchronous active-high reset
//   i_rd_req, i_rd_addr     read request (sampled in IDLE only) and address
//   o_busy, o_done          busy while not IDLE; one-cycle pulse at frame end
//   o_r_en, o_r_addr        single-cycle read strobe / address to register_block
//   i_r_value               read data, valid READ_LATENCY cycles after o_r_en
//   o_tx_data, o_tx_dv      byte and load strobe to uart_tx
//   i_tx_busy               uart_tx busy
module reg_readback_tx #(
    parameter int                    WORD_WIDTH   = 8,
    parameter int                    VALUE_WORDS  = 4,
    parameter int                    READ_LATENCY = 1,
    parameter logic [WORD_WIDTH-1:0] RESP_CODE    = 8'h81
) (
    input  logic                              clk,
    input  logic                              i_reset,
    input  logic                              i_rd_req,
    input  logic [WORD_WIDTH-1:0]             i_rd_addr,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_r_en,
    output logic [WORD_WIDTH-1:0]             o_r_addr,
    input  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_r_value,
    output logic [WORD_WIDTH-1:0]             o_tx_data,
    output logic                              o_tx_dv,
    input  logic                              i_tx_busy
);

    localparam int NBYTES  = VALUE_WORDS + 2;
    localparam int FRAME_W = WORD_WIDTH * NBYTES;
    localparam int CNT_W   = $clog2(VALUE_WORDS + 3);
    localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_RD,
        LOAD,
        WAIT_START,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t               state, next_state;
    logic [WORD_WIDTH-1:0] addr_q;
    logic [FRAME_W-1:0]   frame;
    logic [CNT_W-1:0]     byte_cnt;
    logic [LAT_W-1:0]     lat_cnt;

    logic lat_last;
    logic last_byte;

    assign lat_last  = (lat_cnt == LAT_W'(READ_LATENCY - 1));
    assign last_byte = (byte_cnt == CNT_W'(NBYTES - 1));

    // The frame is held as one shift register so the outgoing byte is always
    // its top slice; shifting in zeros leaves o_tx_data at 0 between frames.
    assign o_tx_data = frame[FRAME_W-1 -: WORD_WIDTH];
    assign o_r_addr  = addr_q;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_busy     = (state != IDLE);
        o_done     = 1'b0;
        o_r_en     = 1'b0;
        o_tx_dv    = 1'b0;
        case (state)
            IDLE: begin
                if (i_rd_req) next_state = READ;
            end
            READ: begin
                o_r_en     = 1'b1;
                next_state = WAIT_RD;
            end
            WAIT_RD: begin
                if (lat_last) next_state = LOAD;
            end
            LOAD: begin
                // Never load uart_tx while it still reports busy.
                if (!i_tx_busy) begin
                    o_tx_dv    = 1'b1;
                    next_state = WAIT_START;
                end
            end
            WAIT_START: begin
                if (i_tx_busy) next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!i_tx_busy) next_state = last_byte ? FINISH : LOAD;
            end
            FINISH: begin
                o_done     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            addr_q   <= '0;
            frame    <= '0;
            byte_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_rd_req) addr_q <= i_rd_addr;
                end
                READ: begin
                    lat_cnt <= '0;
                end
                WAIT_RD: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    // Value captured exactly once; later register writes do
                    // not disturb the frame in flight.
                    if (lat_last) begin
                        frame    <= {RESP_CODE, addr_q, i_r_value};
                        byte_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (!i_tx_busy)
                        frame <= {frame[FRAME_W-WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) byte_cnt <= byte_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_readback_tx.sv
// Bench for reg_readback_tx: register_block and uart_tx models, a frame model
// built from memory contents at request time, one negedge monitor comparing
// every dv byte / read strobe / done pulse, plus literal frame expectations.
module tb_reg_readback_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        busy, done, r_en, tx_dv;
    logic [7:0]  r_addr, tx_data;
    logic [31:0] r_value = '0;
    logic        tx_busy;

    always #5 clk = ~clk;

    reg_readback_tx dut (
        .clk       (clk),
        .i_reset   (rst),
        .i_rd_req  (rd_req),
        .i_rd_addr (rd_addr),
        .o_busy    (busy),
        .o_done    (done),
        .o_r_en    (r_en),
        .o_r_addr  (r_addr),
        .i_r_value (r_value),
        .o_tx_data (tx_data),
        .o_tx_dv   (tx_dv),
        .i_tx_busy (tx_busy)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    logic [7:0]  exp_q [$];
    logic [7:0]  got [$];
    logic [7:0]  raddr_q [$];
    int          ndv = 0, ndone = 0, nren = 0;
    logic        prev_ren = 1'b0;
    logic [7:0]  mon_e;

    int   ucnt = 0;
    logic stuck = 1'b0;
    assign tx_busy = stuck || (ucnt != 0);

    // register_block: one-cycle registered read; uart_tx: busy 3 cycles per byte
    always @(posedge clk) begin
        if (r_en) r_value <= mem[r_addr];
        if (tx_dv) ucnt <= 3;
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_dv) begin
                ndv++;
                chk("dv_while_tx_busy", int'(tx_busy), 0);
                chk("dv_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("tx_byte", int'(tx_data), int'(mon_e));
                end
                got.push_back(tx_data);
            end
            if (r_en) begin
                nren++;
                chk("r_en_single_cycle", int'(prev_ren), 0);
                chk("r_en_expected", int'(raddr_q.size() > 0), 1);
                if (raddr_q.size() > 0) begin
                    mon_e = raddr_q.pop_front();
                    chk("r_addr", int'(r_addr), int'(mon_e));
                end
            end
            if (done) begin
                ndone++;
                chk("done_after_all_bytes", exp_q.size(), 0);
            end
            prev_ren = r_en;
        end
    end

    task automatic req(input logic [7:0] a);
        logic [31:0] v;
        v = mem[a];
        got.delete();
        exp_q.push_back(8'h81);
        exp_q.push_back(a);
        for (int k = 0; k < 4; k++)
            exp_q.push_back(8'((v >> (8 * (3 - k))) & 32'hFF));
        raddr_q.push_back(a);
        rd_addr = a;
        rd_req  = 1'b1;
        @(posedge clk); #1;
        rd_req  = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        d0 = ndone;
        for (int i = 0; i < 600; i++) begin
            if (ndone > d0) break;
            @(posedge clk); #1;
        end
        chk("done_pulses", ndone - d0, 1);
    endtask

    task automatic wait_dv(input int target);
        for (int i = 0; i < 300; i++) begin
            if (ndv >= target) break;
            @(posedge clk); #1;
        end
        chk("dv_reached", int'(ndv >= target), 1);
    endtask

    task automatic chk_frame(input logic [47:0] lit);
        chk("frame_len", got.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < got.size()) chk("frame_byte", int'(got[i]), int'(lit[47 - 8*i -: 8]));
    endtask

    initial begin
        int n0, r0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_r_en", int'(r_en), 0);
        chk("rst_tx_dv", int'(tx_dv), 0);
        chk("rst_r_addr", int'(r_addr), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic frame; register rewritten after capture must not matter
        mem[8'h12] = 32'h3456789A;
        n0 = ndv;
        req(8'h12);
        wait_dv(n0 + 1);
        mem[8'h12] = 32'h0;
        wait_done();
        chk_frame(48'h8112_3456_789A);

        // 2: top address, single read strobe, address held afterwards
        mem[8'hFF] = 32'hbbb00b00;
        r0 = nren;
        req(8'hFF);
        wait_done();
        chk_frame(48'h81FF_BBB0_0B00);
        chk("r_en_count", nren - r0, 1);
        chk("r_addr_hold", int'(r_addr), 8'hFF);

        // 3: request during a frame is ignored
        mem[8'h12] = 32'h3456789A;
        mem[8'h05] = 32'h55555555;
        n0 = ndv; r0 = nren;
        req(8'h12);
        wait_dv(n0 + 1);
        rd_addr = 8'h05; rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        wait_done();
        chk_frame(48'h8112_3456_789A);
        chk("ignored_req_r_en", nren - r0, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("ignored_req_idle", int'(busy), 0);

        // 4: uart stuck busy before the first byte
        mem[8'h20] = 32'h11223344;
        stuck = 1'b1;
        n0 = ndv;
        req(8'h20);
        repeat (50) @(posedge clk);
        #1;
        chk("stuck_no_dv", ndv - n0, 0);
        chk("stuck_busy", int'(busy), 1);
        stuck = 1'b0;
        wait_done();
        chk_frame(48'h8120_1122_3344);

        // 5: reset after two bytes, then a clean frame
        mem[8'h30] = 32'hCAFEF00D;
        mem[8'h01] = 32'h01020304;
        n0 = ndv;
        req(8'h30);
        wait_dv(n0 + 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("reset_busy", int'(busy), 0);
        n0 = ndv;
        repeat (20) @(posedge clk);
        #1;
        chk("reset_no_more_dv", ndv - n0, 0);
        req(8'h01);
        wait_done();
        chk_frame(48'h8101_0102_0304);

        // reset together with request: request dropped
        r0 = nren;
        rst = 1'b1; rd_req = 1'b1; rd_addr = 8'h40;
        @(posedge clk); #1;
        rst = 1'b0; rd_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_req_busy", int'(busy), 0);
        chk("rst_req_r_en", nren - r0, 0);

        // 6: back-to-back requests, second on the cycle after o_done
        mem[8'h00] = 32'hDEADBEEF;
        mem[8'h01] = 32'h55667788;
        req(8'h00);
        wait_done();
        chk_frame(48'h8100_DEAD_BEEF);
        req(8'h01);
        wait_done();
        chk_frame(48'h8101_5566_7788);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
